// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared types for the sync_fifo block.
// Defines the encoding of the per-cycle FIFO operation.
package sync_fifo_pkg;

  // Accepted operations in one cycle, packed as {write, read}.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_RD    = 2'b01,
    OP_WR    = 2'b10,
    OP_WR_RD = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e decode_op(input logic wr_acc, input logic rd_acc);
    return fifo_op_e'({wr_acc, rd_acc});
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// sync_fifo_if: write/read handshake bundle of sync_fifo.
// Optional macro SYNC_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow outputs.
interface sync_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] din;
  logic                  wr_en;
  logic                  full;
  logic [DATA_WIDTH-1:0] dout;
  logic                  rd_en;
  logic                  empty;
  logic [ADDR_WIDTH-1:0] elemcnt;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic                  overflow;
  logic                  underflow;

  modport master (output din, wr_en, rd_en,
                  input  full, dout, empty, elemcnt, overflow, underflow);
  modport slave  (input  din, wr_en, rd_en,
                  output full, dout, empty, elemcnt, overflow, underflow);
`else
  modport master (output din, wr_en, rd_en,
                  input  full, dout, empty, elemcnt);
  modport slave  (input  din, wr_en, rd_en,
                  output full, dout, empty, elemcnt);
`endif
endinterface

// File: rtl/sync_fifo_sdp_ram.sv
// sync_fifo_sdp_ram (sdp_ram): simple dual-port RAM, synchronous write port,
// registered read port. Written so the storage maps onto block RAM with the
// output register's synchronous reset.
module sync_fifo_sdp_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Write port: storage contents are never reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: output register, cleared by reset, holds when no read.
  always_ff @(posedge clk) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data, occupancy count
// and full/empty flags. One slot is kept free, so capacity is 2**ADDR_WIDTH-1.
// Optional macro SYNC_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow flags.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  sync_fifo_if.slave     bus
);

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] CNT_MAX = '1;

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] elemcnt;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  full;
  logic                  empty;
  logic                  wr_acc;
  logic                  rd_acc;
  fifo_op_e              op;

  // Flags come straight from the count so they never disagree with it.
  assign full  = (elemcnt == CNT_MAX);
  assign empty = (elemcnt == '0);

  // Acceptance uses pre-edge state; clear overrides both strobes.
  assign wr_acc = bus.wr_en && !full  && !clr && rst_n;
  assign rd_acc = bus.rd_en && !empty && !clr && rst_n;
  assign op     = decode_op(wr_acc, rd_acc);

  sync_fifo_sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (bus.din),
    .re    (rd_acc),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // Pointers and count advance together on accepted operations.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      elemcnt <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      unique case (op)
        OP_WR:   elemcnt <= elemcnt + PTR_ONE;
        OP_RD:   elemcnt <= elemcnt - PTR_ONE;
        default: elemcnt <= elemcnt;
      endcase
    end
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow;
  logic underflow;

  // Sticky error flags record any strobe that had to be dropped.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (bus.wr_en && full)  overflow  <= 1'b1;
      if (bus.rd_en && empty) underflow <= 1'b1;
    end
  end

  assign bus.overflow  = overflow;
  assign bus.underflow = underflow;
`endif

  assign bus.full    = full;
  assign bus.empty   = empty;
  assign bus.elemcnt = elemcnt;
  assign bus.dout    = rd_data;

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed and randomized stimulus for sync_fifo, checked
// every cycle against a queue-based reference model.
module tb_sync_fifo;
  import sync_fifo_pkg::*;

  localparam int DW  = 32;
  localparam int AW  = 8;
  localparam int CAP = (1 << AW) - 1;

  logic clk;
  logic rst_n;
  logic clr;

  sync_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) fif ();

  sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (fif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] model_dout = '0;
  bit            model_ovf  = 1'b0;
  bit            model_udf  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // One clock: drive strobes, update the model from pre-edge occupancy, compare.
  task automatic step(input bit wr, input logic [DW-1:0] d, input bit rd,
                      input bit c = 1'b0, input bit rs = 1'b0);
    int sz;
    fif.wr_en = wr;
    fif.din   = d;
    fif.rd_en = rd;
    clr       = c;
    rst_n     = !rs;
    @(posedge clk);
    sz = model_q.size();
    if (rs) begin
      model_q.delete();
      model_dout = '0;
      model_ovf  = 1'b0;
      model_udf  = 1'b0;
    end else if (c) begin
      model_q.delete();
      model_ovf = 1'b0;
      model_udf = 1'b0;
    end else begin
      if (wr && sz == CAP) model_ovf = 1'b1;
      if (rd && sz == 0)   model_udf = 1'b1;
      if (rd && sz > 0)    model_dout = model_q.pop_front();
      if (wr && sz < CAP)  model_q.push_back(d);
    end
    #1;
    check("elemcnt", 32'(fif.elemcnt), 32'(model_q.size()));
    check("empty",   32'(fif.empty),   32'(model_q.size() == 0));
    check("full",    32'(fif.full),    32'(model_q.size() == CAP));
    check("dout",    fif.dout,         model_dout);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    check("overflow",  32'(fif.overflow),  32'(model_ovf));
    check("underflow", 32'(fif.underflow), 32'(model_udf));
`endif
  endtask

  task automatic drain();
    while (model_q.size() > 0) step(1'b0, '0, 1'b1);
  endtask

  initial begin
    fif.din   = '0;
    fif.wr_en = 1'b0;
    fif.rd_en = 1'b0;
    clr       = 1'b0;
    rst_n     = 1'b0;

    // Reset, then idle.
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
    check("rst_elemcnt", 32'(fif.elemcnt), 32'd0);
    check("rst_empty",   32'(fif.empty),   32'd1);
    check("rst_dout",    fif.dout,         32'd0);

    // Three writes, three reads, one read while empty.
    step(1'b1, 32'h11, 1'b0);
    step(1'b1, 32'h22, 1'b0);
    step(1'b1, 32'h33, 1'b0);
    check("cnt3", 32'(fif.elemcnt), 32'd3);
    step(1'b0, '0, 1'b1);
    check("rd11", fif.dout, 32'h11);
    step(1'b0, '0, 1'b1);
    check("rd22", fif.dout, 32'h22);
    step(1'b0, '0, 1'b1);
    check("rd33", fif.dout, 32'h33);
    step(1'b0, '0, 1'b1);
    check("rd_empty_hold", fif.dout, 32'h33);
    check("empty_after",   32'(fif.empty), 32'd1);

    // Fill to capacity, one dropped write, read everything back.
    for (int i = 0; i < CAP; i++) step(1'b1, $urandom, 1'b0);
    check("fill_full", 32'(fif.full), 32'd1);
    check("fill_cnt",  32'(fif.elemcnt), 32'(CAP));
    step(1'b1, 32'hDEAD_BEEF, 1'b0);
    drain();

    // Move pointers near the top so the next test wraps.
    for (int i = 0; i < 245; i++) step(1'b1, $urandom, 1'b0);
    drain();

    // Simultaneous read+write at occupancy 5 across pointer wrap.
    for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, $urandom, 1'b1);
    check("simul_cnt", 32'(fif.elemcnt), 32'd5);
    drain();

    // Clear with a concurrent write at occupancy 7.
    for (int i = 0; i < 7; i++) step(1'b1, $urandom, 1'b0);
    step(1'b1, 32'h5555_AAAA, 1'b0, 1'b1);
    check("clr_cnt",   32'(fif.elemcnt), 32'd0);
    check("clr_empty", 32'(fif.empty),   32'd1);
    step(1'b0, '0, 1'b1);

    // Reset mid-stream at occupancy 40, then new traffic.
    for (int i = 0; i < 40; i++) step(1'b1, $urandom, 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("rst_mid_cnt",  32'(fif.elemcnt), 32'd0);
    check("rst_mid_dout", fif.dout,         32'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 32'hA0 + 32'(i), 1'b0);
    drain();

    // Random traffic with phases biased toward filling and draining.
    for (int i = 0; i < 2000; i++) begin
      int wp = ((i / 250) % 2 == 0) ? 75 : 35;
      step($urandom_range(99) < wp, $urandom, $urandom_range(99) < 55,
           $urandom_range(199) == 0, $urandom_range(499) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
